// File: rtl/alu_pkg.sv
// Shared ALU opcodes, funct3 codes and widths.
// Used by alu, alu_decode and alu_issue_stage.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Shift-amount immediates only use imm[4:0].
  function automatic logic is_shift_f3(
    input logic [2:0] f3
  );
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// funct3/funct7_5/is_op_imm -> alu_control map.
// Ports: funct3, funct7_5, is_op_imm in; alu_control out.
module alu_decode
  import alu_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  is_op_imm,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (funct3)
      F3_ADD: begin
        // bit 30 of ADDI is imm, never SUB
        if (!is_op_imm && funct7_5)
          alu_control = ALU_SUB;
        else
          alu_control = ALU_ADD;
      end
      F3_SLL:  alu_control = ALU_SLL;
      F3_SLT:  alu_control = ALU_SLT;
      F3_SLTU: alu_control = ALU_SLTU;
      F3_XOR:  alu_control = ALU_XOR;
      F3_SR: begin
        // SRAI keeps bit 30 in its encoding too
        if (funct7_5)
          alu_control = ALU_SRA;
        else
          alu_control = ALU_SRL;
      end
      F3_OR:   alu_control = ALU_OR;
      F3_AND:  alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage: forwarding, decode, operand register for alu.
// Ports: in_* handshake + decoded fields, fwd_* bypass, out_* to alu.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_op_imm,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic [XLEN-1:0]       rs1_val,
  input  logic [XLEN-1:0]       rs2_val,
  input  logic [XLEN-1:0]       imm,
  input  logic [4:0]            rd_addr,
  input  logic                  fwd_mem_en,
  input  logic [4:0]            fwd_mem_rd,
  input  logic [XLEN-1:0]       fwd_mem_data,
  input  logic                  fwd_wb_en,
  input  logic [4:0]            fwd_wb_rd,
  input  logic [XLEN-1:0]       fwd_wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_a,
  output logic [XLEN-1:0]       out_b,
  output logic [ALU_CTRL_W-1:0] out_alu_control,
  output logic [4:0]            out_rd
);

  logic                  accept;
  logic [ALU_CTRL_W-1:0] dec_ctrl;
  logic [XLEN-1:0]       a_fwd;
  logic [XLEN-1:0]       b_fwd;
  logic [XLEN-1:0]       b_sel;
  logic                  a_mem_hit;
  logic                  a_wb_hit;
  logic                  b_mem_hit;
  logic                  b_wb_hit;

  alu_decode u_dec (
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .is_op_imm   (is_op_imm),
    .alu_control (dec_ctrl)
  );

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // x0 is hardwired, so never bypass it
  assign a_mem_hit = fwd_mem_en && (rs1_addr != 5'd0)
                  && (fwd_mem_rd == rs1_addr);
  assign a_wb_hit  = fwd_wb_en && (rs1_addr != 5'd0)
                  && (fwd_wb_rd == rs1_addr);
  assign b_mem_hit = fwd_mem_en && (rs2_addr != 5'd0)
                  && (fwd_mem_rd == rs2_addr);
  assign b_wb_hit  = fwd_wb_en && (rs2_addr != 5'd0)
                  && (fwd_wb_rd == rs2_addr);

  // MEM is younger than WB, so it wins
  always_comb begin
    a_fwd = rs1_val;
    unique case (1'b1)
      a_mem_hit:             a_fwd = fwd_mem_data;
      !a_mem_hit && a_wb_hit: a_fwd = fwd_wb_data;
      default:               a_fwd = rs1_val;
    endcase
  end

  always_comb begin
    b_fwd = rs2_val;
    unique case (1'b1)
      b_mem_hit:             b_fwd = fwd_mem_data;
      !b_mem_hit && b_wb_hit: b_fwd = fwd_wb_data;
      default:               b_fwd = rs2_val;
    endcase
  end

  always_comb begin
    b_sel = imm;
    if (!is_op_imm)
      b_sel = b_fwd;
    else if (is_shift_f3(funct3))
      b_sel = {{(XLEN-5){1'b0}}, imm[4:0]};
    else
      b_sel = imm;
  end

  // Data regs only move on accept; flush just drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_a           <= '0;
      out_b           <= '0;
      out_alu_control <= ALU_ADD;
      out_rd          <= 5'd0;
    end else if (flush) begin
      out_valid       <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_a           <= a_fwd;
      out_b           <= b_sel;
      out_alu_control <= dec_ctrl;
      out_rd          <= rd_addr;
    end else if (out_ready) begin
      out_valid       <= 1'b0;
    end
  end

endmodule
